// File: rtl/bht_predictor_if.sv
// Fetch/EX-side bus of the branch predictor: ID lookup address and
// prediction, plus the EX-stage training pulse with resolved outcome.
interface bht_predictor_if;
  logic [31:0] pc_ID;
  logic        pre_br;
  logic [31:0] pre_pc;
  logic        upd_en;
  logic        real_br;
  logic [31:0] pc_EX;
  logic [31:0] br_target;

  // Pipeline side: drives lookup and training, receives the prediction.
  modport master (
    output pc_ID, upd_en, real_br, pc_EX, br_target,
    input  pre_br, pre_pc
  );

  // Predictor side.
  modport slave (
    input  pc_ID, upd_en, real_br, pc_EX, br_target,
    output pre_br, pre_pc
  );
endinterface

// File: rtl/bht_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counters plus a tagged
// target buffer. Zero-latency lookup on pc_ID, training on pc_EX when upd_en.
// Optional macro BP_BYPASS_EN: forward a same-index update to the lookup in
// the same cycle; undefined, the lookup sees stored contents only.
module bht_predictor #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  INIT_CNT = 2'b01
) (
  input logic            cpu_clk,
  input logic            cpu_rst_n,
  bht_predictor_if.slave bp
);

  localparam int unsigned TAG_W   = 32 - IDX_W - 2;
  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic             valid_q  [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [1:0]       wr_cnt_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [31:0]      wr_target_d;

  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  logic [31:0]      lk_target;
  logic [1:0]       lk_cnt;
  logic             lk_hit;
  logic             pre_br_d;

  // Byte-offset bits of the resolving PC carry no index/tag information.
  logic unused_pc_ex_lsbs;
  assign unused_pc_ex_lsbs = ^bp.pc_EX[1:0];

  // New contents of the entry addressed by pc_EX (train on hit, allocate on miss).
  always_comb begin
    ex_idx      = bp.pc_EX[IDX_W+1:2];
    ex_tag      = bp.pc_EX[31:IDX_W+2];
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    wr_tag_d    = ex_tag;
    wr_target_d = bp.br_target;
    wr_cnt_d    = bp.real_br ? 2'b10 : INIT_CNT;
    if (ex_hit) begin
      if (bp.real_br) begin
        wr_cnt_d = (cnt_q[ex_idx] == 2'b11) ? 2'b11 : cnt_q[ex_idx] + 2'b01;
      end else begin
        wr_cnt_d    = (cnt_q[ex_idx] == 2'b00) ? 2'b00 : cnt_q[ex_idx] - 2'b01;
        wr_target_d = target_q[ex_idx];
      end
    end
  end

  // Valid bits and counters: cleared to the allocation baseline on reset.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      valid_q <= '{default: 1'b0};
      cnt_q   <= '{default: INIT_CNT};
    end else if (bp.upd_en) begin
      valid_q[ex_idx] <= 1'b1;
      cnt_q[ex_idx]   <= wr_cnt_d;
    end
  end

  // Tags and targets are unreset storage; they only matter once valid is set.
  always_ff @(posedge cpu_clk) begin
    if (bp.upd_en && cpu_rst_n) begin
      tag_q[ex_idx]    <= wr_tag_d;
      target_q[ex_idx] <= wr_target_d;
    end
  end

  // Lookup for the instruction in ID; reset forces a not-taken prediction.
  always_comb begin
    id_idx    = bp.pc_ID[IDX_W+1:2];
    id_tag    = bp.pc_ID[31:IDX_W+2];
    lk_valid  = valid_q[id_idx];
    lk_tag    = tag_q[id_idx];
    lk_target = target_q[id_idx];
    lk_cnt    = cnt_q[id_idx];
`ifdef BP_BYPASS_EN
    if (bp.upd_en && (ex_idx == id_idx)) begin
      lk_valid  = 1'b1;
      lk_tag    = wr_tag_d;
      lk_target = wr_target_d;
      lk_cnt    = wr_cnt_d;
    end
`endif
    lk_hit     = cpu_rst_n && lk_valid && (lk_tag == id_tag);
    pre_br_d   = lk_hit && lk_cnt[1];
    bp.pre_br  = pre_br_d;
    bp.pre_pc  = pre_br_d ? lk_target : bp.pc_ID + 32'd4;
  end

endmodule
